// File: rtl/nes_joypad_responder_if.sv
// Joypad pin bundle between a host (rp2a03-style poller or bench) and the pad responder.
// The host drives the strobes and the button source; the responder returns serial data and status.
interface nes_joypad_responder_if #(
  parameter int N_BITS = 8
);
  logic              jp_clk_in;
  logic              jp_latch_in;
  logic [N_BITS-1:0] btn_in;
  logic              jp_data_out;
  logic              poll_out;
  logic [4:0]        bit_cnt_out;

  modport master (
    output jp_clk_in, jp_latch_in, btn_in,
    input  jp_data_out, poll_out, bit_cnt_out
  );

  modport slave (
    input  jp_clk_in, jp_latch_in, btn_in,
    output jp_data_out, poll_out, bit_cnt_out
  );
endinterface

// File: rtl/nes_joypad_responder.sv
// CD4021-style NES pad: parallel load while latch is high, shift on jp_clk rising edges.
// Strobe edges act SYNC_STAGES+1 cycles after the pin; no backpressure, the host paces every read.
module nes_joypad_responder #(
  parameter int   N_BITS      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b0
) (
  input logic                   clk_in,
  input logic                   nrst_in,
  nes_joypad_responder_if.slave jp
);

  typedef enum logic {ST_LOAD, ST_SHIFT} state_t;

  localparam logic [4:0] CNT_MAX = 5'(N_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [N_BITS-1:0]      sr_q, sr_d;
  logic [4:0]             cnt_q, cnt_d;

  logic clk_s, latch_s, clk_rise;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign latch_s  = latch_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev_q;

  // The state register doubles as the previous synchronised latch value.
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], jp.jp_clk_in};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], jp.jp_latch_in};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (!latch_s) begin
          // Leaving load: hold the first bit even if a clock edge lands now.
          state_d = ST_SHIFT;
        end else begin
          sr_d  = ~jp.btn_in;
          cnt_d = 5'd0;
        end
      end
      ST_SHIFT: begin
        if (latch_s) begin
          state_d = ST_LOAD;
          sr_d    = ~jp.btn_in;
          cnt_d   = 5'd0;
        end else if (clk_rise) begin
          sr_d           = sr_q >> 1;
          sr_d[N_BITS-1] = FILL_BIT;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      clk_sync_q   <= '0;
      latch_sync_q <= '0;
      clk_prev_q   <= 1'b0;
      state_q      <= ST_SHIFT;
      sr_q         <= '1;
      cnt_q        <= 5'd0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      latch_sync_q <= latch_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign jp.jp_data_out = sr_q[0];
  assign jp.poll_out    = (state_q == ST_LOAD) & ~latch_s;
  assign jp.bit_cnt_out = cnt_q;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Bench for nes_joypad_responder: fixed vector table, hand-written corner sequences, random polls.
module tb_nes_joypad_responder;

  localparam int   NB   = 8;
  localparam logic FILL = 1'b0;

  logic clk_in  = 1'b0;
  logic nrst_in = 1'b0;

  nes_joypad_responder_if #(.N_BITS(NB)) jp();

  nes_joypad_responder #(.N_BITS(NB), .SYNC_STAGES(2), .FILL_BIT(FILL)) dut (
    .clk_in  (clk_in),
    .nrst_in (nrst_in),
    .jp      (jp.slave)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int poll_cnt = 0;

  always @(negedge clk_in) if (jp.poll_out === 1'b1) poll_cnt++;

  // Reference model: word captured at load, read position, over-read yields FILL.
  logic [NB-1:0] m_word;
  int            m_cnt;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] wire_exp;
    int         nreads;
    int         cnt_exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic latch_poll(input logic [7:0] b);
    int p0;
    jp.btn_in      = b;
    jp.jp_latch_in = 1'b1;
    cyc(12);
    m_word = ~b;
    m_cnt  = 0;
    p0     = poll_cnt;
    jp.jp_latch_in = 1'b0;
    cyc(8);
    check("poll_pulse", 32'(poll_cnt - p0), 32'd1);
    check("cnt_after_latch", 32'(jp.bit_cnt_out), 32'd0);
  endtask

  task automatic read_one(input logic exp_bit, input int exp_cnt, input int hi, input int lo);
    check("wire_bit", 32'(jp.jp_data_out), 32'(exp_bit));
    jp.jp_clk_in = 1'b1;
    cyc(hi);
    jp.jp_clk_in = 1'b0;
    cyc(lo);
    check("bit_cnt", 32'(jp.bit_cnt_out), 32'(exp_cnt));
  endtask

  task automatic model_read(input int hi, input int lo);
    logic eb;
    eb = (m_cnt < NB) ? m_word[m_cnt] : FILL;
    if (m_cnt < NB) m_cnt++;
    read_one(eb, m_cnt, hi, lo);
  endtask

  initial begin
    logic [7:0] w;
    int n;

    vecs[0] = '{btn: 8'h85, wire_exp: 8'h7A, nreads: 12, cnt_exp: 8};
    vecs[1] = '{btn: 8'h00, wire_exp: 8'hFF, nreads: 9,  cnt_exp: 8};
    vecs[2] = '{btn: 8'hFF, wire_exp: 8'h00, nreads: 10, cnt_exp: 8};
    vecs[3] = '{btn: 8'h5A, wire_exp: 8'hA5, nreads: 8,  cnt_exp: 8};
    vecs[4] = '{btn: 8'h3C, wire_exp: 8'hC3, nreads: 3,  cnt_exp: 3};

    jp.jp_clk_in   = 1'b0;
    jp.jp_latch_in = 1'b0;
    jp.btn_in      = 8'hFF;

    // Reset holds regardless of clk_in activity.
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      check("rst_data", 32'(jp.jp_data_out), 32'd1);
      check("rst_cnt", 32'(jp.bit_cnt_out), 32'd0);
      check("rst_poll", 32'(jp.poll_out), 32'd0);
    end
    nrst_in = 1'b1;
    cyc(4);

    // Table vectors: wire bit i comes straight from the table, FILL beyond NB.
    for (int v = 0; v < 5; v++) begin
      latch_poll(vecs[v].btn);
      w = vecs[v].wire_exp;
      for (int i = 0; i < vecs[v].nreads; i++) begin
        read_one((i < NB) ? w[i] : FILL, (i + 1 < NB) ? i + 1 : NB, 10, 10);
      end
      check("tbl_end_cnt", 32'(jp.bit_cnt_out), 32'(vecs[v].cnt_exp));
    end

    // Latch and clock rising together: load wins.
    latch_poll(8'h85);
    for (int i = 0; i < 3; i++) model_read(6, 6);
    jp.jp_latch_in = 1'b1;
    jp.jp_clk_in   = 1'b1;
    cyc(6);
    check("lp_cnt", 32'(jp.bit_cnt_out), 32'd0);
    check("lp_data", 32'(jp.jp_data_out), 32'd0);
    jp.btn_in = 8'h84;
    cyc(3);
    check("lp_follow", 32'(jp.jp_data_out), 32'd1);
    // Latch falling with clock rising together: first bit is not shifted away.
    jp.jp_clk_in = 1'b0;
    cyc(6);
    jp.jp_latch_in = 1'b0;
    jp.jp_clk_in   = 1'b1;
    cyc(8);
    check("lf_cnt", 32'(jp.bit_cnt_out), 32'd0);
    check("lf_data", 32'(jp.jp_data_out), 32'd1);
    jp.jp_clk_in = 1'b0;
    cyc(6);
    check("lf_fall_data", 32'(jp.jp_data_out), 32'd1);
    m_word = ~8'h84;
    m_cnt  = 0;
    for (int i = 0; i < NB; i++) model_read(5, 5);

    // Button change mid-poll only shows on the next poll.
    latch_poll(8'h01);
    for (int i = 0; i < 3; i++) model_read(8, 8);
    jp.btn_in = 8'h02;
    for (int i = 3; i < NB; i++) model_read(8, 8);
    latch_poll(8'h02);
    model_read(8, 8);
    check("next_poll_b", 32'(jp.jp_data_out), 32'd0);

    // Asynchronous reset mid-poll, checked before any further clk_in edge.
    latch_poll(8'h5A);
    for (int i = 0; i < 4; i++) model_read(7, 7);
    #1;
    nrst_in = 1'b0;
    #1;
    check("arst_data", 32'(jp.jp_data_out), 32'd1);
    check("arst_cnt", 32'(jp.bit_cnt_out), 32'd0);
    check("arst_poll", 32'(jp.poll_out), 32'd0);
    cyc(3);
    nrst_in = 1'b1;
    cyc(3);
    latch_poll(8'h80);
    w = 8'h7F;
    for (int i = 0; i < NB; i++) read_one(w[i], i + 1, 10, 10);

    // Random polls, random strobe widths, random button noise during shifting.
    for (int r = 0; r < 25; r++) begin
      latch_poll(8'($urandom));
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) jp.btn_in = 8'($urandom);
        model_read($urandom_range(4, 10), $urandom_range(4, 10));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nes_joypad_responder.md
Name: nes_joypad_responder

Overview:
Device-side model of a standard NES controller, built around a CD4021-style parallel-in/serial-out shift register. It answers the joypad protocol the rp2a03 joypad block drives: it receives the latch and clk strobes and returns serial button data.
- Button state comes from a host-side source on btn_in (HCI, a PS/2 bridge, or a bench).
- In nes_top, the block replaces a physical pad on NES_JOYPAD_DATA1/2.
- The same block serves as the loop-back responder in joypad verification.

Parameters:
N_BITS, 8, number of buttons shifted per poll (1..31); 8 models a standard pad, 24 models a four-score chain.
SYNC_STAGES, 2, flip-flop stages used to synchronise jp_clk_in and jp_latch_in (minimum 2).
FILL_BIT, 1'b0, wire level shifted in behind the last button. 0 makes the CPU read 1 after N_BITS reads, as an official pad does.

Ports:
clk_in  input  1  system clock (100 MHz in nes_top)
nrst_in  input  1  asynchronous active-low reset
jp_clk_in  input  1  joypad shift clock from the host (NES_JOYPAD_CLK)
jp_latch_in  input  1  joypad latch strobe from the host (NES_JOYPAD_LATCH)
btn_in  input  N_BITS  button state, 1 = pressed; bit0 = A, then B, Select, Start, Up, Down, Left, Right
jp_data_out  output  1  serial data to the host, active-low (0 = pressed)
poll_out  output  1  one-cycle pulse on each synchronised latch falling edge
bit_cnt_out  output  5  number of shifts since the last latch, saturating at N_BITS

Behaviour:
- Reset state (nrst_in low, takes effect immediately):
  - synchroniser flops = 0
  - shift register = all ones (no button pressed on the wire)
  - jp_data_out = 1, poll_out = 0, bit_cnt_out = 0
- Synchronisation: jp_clk_in and jp_latch_in each pass through SYNC_STAGES flops. One further register holds the previous synchronised value for edge detection.
  - Edge-detect latency from the input pin = SYNC_STAGES+1 cycles.
  - Pulses shorter than SYNC_STAGES+1 cycles need not be seen.
- Shift register sr[N_BITS-1:0] holds wire levels; jp_data_out is always driven from sr[0] through a register, never combinationally.
- State machine, two states:
  - LOAD: synchronised latch = 1.
    - Every cycle: sr <= ~btn_in, bit_cnt <= 0.
    - jp_data_out follows ~btn_in[0] with 1 cycle of latency.
    - Clock edges are ignored (parallel load has priority).
  - SHIFT: synchronised latch = 0.
    - On a synchronised jp_clk rising edge: sr <= {FILL_BIT, sr[N_BITS-1:1]}, bit_cnt <= min(bit_cnt+1, N_BITS).
    - Falling clock edges change nothing.
  - Transitions:
    - LOAD -> SHIFT on the latch falling edge; poll_out = 1 in that same cycle.
    - SHIFT -> LOAD on the latch rising edge.
- Simultaneous events:
  - Latch rising edge and clock rising edge in the same cycle: load wins, no shift.
  - Latch falling edge and clock rising edge in the same cycle: the shift is suppressed. The first bit stays valid until the next clock edge.
- Wrap-around / over-read: after N_BITS shifts, jp_data_out = FILL_BIT for any further edges, and bit_cnt_out holds at N_BITS.
- Timing of btn_in changes: in SHIFT they have no effect on the current poll. The new value is captured only at the next LOAD.
- Reset mid-poll: the state returns to the reset values. The next poll is served normally after nrst_in is released.
- No combinational path exists from any input to any output.

Test Plan:
- Reset: hold nrst_in = 0 with btn_in = 8'hFF -> jp_data_out = 1, bit_cnt_out = 0, poll_out = 0, independent of clk_in.
- Standard poll: btn_in = 8'b1000_0101 (A, Select, Right); latch high 12 cycles, low, then 8 jp_clk pulses of 10 cycles high/10 cycles low:
  - poll_out pulses once.
  - Wire sequence read before each rising edge: 0,1,0,1,1,1,1,0.
  - bit_cnt_out ends at 8.
- Over-read: continue the poll above with 4 more clock pulses -> jp_data_out = 0 (FILL_BIT) for all 4, bit_cnt_out stays at 8.
- Load priority: raise latch and clock in the same cycle during a poll -> no shift, bit_cnt_out = 0, jp_data_out = ~btn_in[0].
- Mid-poll button change: change btn_in from 8'h01 to 8'h02 after 3 shifts -> remaining bits still come from 8'h01; the next poll returns B pressed (bit1 wire = 0).
- Asynchronous reset mid-poll after 4 shifts -> outputs take reset values with no clk_in edge; a subsequent full poll of btn_in = 8'h80 yields wire 1,1,1,1,1,1,1,0.
